// File: rtl/mem_access_stage.sv
// Memory-access stage: takes valE/valA from execute, runs one req/ack RAM access, returns valM/valE/dstE to writeback.
// Latency: 1 cycle from accept to out_valid for non-memory ops; 2+N for accesses (N = cycles from ram_req rise to ram_ack).
// Backpressure: in_ready only in IDLE; the result is held stable in HOLD until out_ready; a stuck access aborts after TIMEOUT cycles.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              upstream handshake; in_mem_rd, in_mem_wr, in_valE, in_valA, in_dstE
//   out_valid/out_ready            downstream handshake; out_valE, out_valM, out_dstE, out_err
//   ram_req/ram_ack                RAM handshake; ram_we, ram_addr, ram_wdata, ram_rdata
module mem_access_stage #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_rd,
  input  logic              in_mem_wr,
  input  logic [DATA_W-1:0] in_valE,
  input  logic [DATA_W-1:0] in_valA,
  input  logic [3:0]        in_dstE,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_valE,
  output logic [DATA_W-1:0] out_valM,
  output logic [3:0]        out_dstE,
  output logic              out_err,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] vale_q, vale_d;
  logic [DATA_W-1:0] valm_q, valm_d;
  logic [3:0]        dste_q, dste_d;
  logic              err_q, err_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign out_valE  = vale_q;
  assign out_valM  = valm_q;
  assign out_dstE  = dste_q;
  assign out_err   = err_q;
  assign ram_req   = req_q;
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      vale_q  <= '0;
      valm_q  <= '0;
      dste_q  <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      vale_q  <= vale_d;
      valm_q  <= valm_d;
      dste_q  <= dste_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    vale_d  = vale_q;
    valm_d  = valm_q;
    dste_d  = dste_q;
    err_d   = err_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          vale_d = in_valE;
          dste_d = in_dstE;
          rd_d   = in_mem_rd;
          valm_d = '0;
          err_d  = 1'b0;
          cnt_d  = '0;
          if (in_mem_rd && in_mem_wr) begin
            // Conflicting request: report it without touching the RAM.
            err_d   = 1'b1;
            state_d = HOLD;
          end else if (in_mem_rd || in_mem_wr) begin
            req_d   = 1'b1;
            we_d    = in_mem_wr;
            addr_d  = in_valE[ADDR_W-1:0];
            wdata_d = in_valA;
            state_d = REQ;
          end else begin
            state_d = HOLD;
          end
        end
      end

      REQ: begin
        // Ack is checked first so an ack on the final allowed cycle still completes.
        if (ram_ack) begin
          valm_d  = rd_q ? ram_rdata : '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          valm_d  = '0;
          err_d   = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_mem_rd, in_mem_wr;
  logic [DW-1:0] in_valE, in_valA;
  logic [3:0]    in_dstE;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_valE, out_valM;
  logic [3:0]    out_dstE;
  logic          out_err;
  logic          ram_req, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_ack;

  int n_assert = 0;
  int n_fail   = 0;
  logic [DW-1:0] mem [256];

  mem_access_stage #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .in_valE(in_valE), .in_valA(in_valA), .in_dstE(in_dstE),
    .out_valid(out_valid), .out_ready(out_ready), .out_valE(out_valE), .out_valM(out_valM),
    .out_dstE(out_dstE), .out_err(out_err),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_err"}, out_err, 0);
    chk({tag, "_ram_req"}, ram_req, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_data_outs"}, {out_valE, out_valM, out_dstE, ram_addr, ram_wdata}, 0);
  endtask

  // One instruction through the stage. The bench acts as the RAM: it acks
  // `delay` cycles after ram_req is first seen (never if delay >= TO), and
  // holds the result for `bp` extra cycles before consuming it.
  task automatic run_op(input logic rd, input logic wr, input logic [DW-1:0] ve,
                        input logic [DW-1:0] va, input logic [3:0] dst,
                        input int delay, input int bp);
    int            reqc, lat, exp_req;
    bit            got;
    logic [DW-1:0] exp_m;
    logic          exp_err;
    logic [DW-1:0] hv_e, hv_m;
    logic [3:0]    hv_d;
    logic          hv_err;

    if (rd && wr) begin
      exp_req = 0; exp_err = 1'b1; exp_m = '0;
    end else if (!rd && !wr) begin
      exp_req = 0; exp_err = 1'b0; exp_m = '0;
    end else if (delay < TO) begin
      exp_req = delay + 1; exp_err = 1'b0; exp_m = rd ? mem[ve] : '0;
    end else begin
      exp_req = TO; exp_err = 1'b1; exp_m = '0;
    end

    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; in_mem_rd = rd; in_mem_wr = wr;
    in_valE = ve; in_valA = va; in_dstE = dst;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_mem_rd = $urandom; in_mem_wr = $urandom;
    in_valE = $urandom; in_valA = $urandom; in_dstE = $urandom;

    reqc = 0; lat = 0; got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      lat++;
      ram_ack = 1'b0;
      if (out_valid) begin
        got = 1;
      end else if (ram_req) begin
        reqc++;
        chk("ram_addr", ram_addr, ve);
        chk("ram_we", ram_we, wr);
        if (wr) chk("ram_wdata", ram_wdata, va);
        if (reqc == delay + 1) begin
          ram_ack   = 1'b1;
          ram_rdata = mem[ram_addr];
          if (ram_we) mem[ram_addr] = ram_wdata;
        end else begin
          ram_rdata = $urandom;
        end
      end
    end
    ram_ack = 1'b0;

    chk("out_valid_seen", got, 1);
    chk("ram_req_cycles", reqc, exp_req);
    chk("latency", lat, (exp_req == 0) ? 1 : exp_req + 1);
    chk("out_valE", out_valE, ve);
    chk("out_valM", out_valM, exp_m);
    chk("out_dstE", out_dstE, dst);
    chk("out_err", out_err, exp_err);
    chk("hold_ram_req", ram_req, 0);
    chk("hold_in_ready", in_ready, 0);
    hv_e = out_valE; hv_m = out_valM; hv_d = out_dstE; hv_err = out_err;

    for (int b = 0; b < bp; b++) begin
      ram_ack = $urandom;
      ram_rdata = $urandom;
      @(negedge clk);
      ram_ack = 1'b0;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_ram_req", ram_req, 0);
      chk("bp_stable", {out_valE, out_valM, out_dstE, out_err}, {hv_e, hv_m, hv_d, hv_err});
    end

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);
  endtask

  initial begin
    int dly;
    rst_n = 1'b0; in_valid = 1'b0; in_mem_rd = 1'b0; in_mem_wr = 1'b0;
    in_valE = '0; in_valA = '0; in_dstE = '0; out_ready = 1'b0;
    ram_rdata = '0; ram_ack = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 8'hA5;

    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // pass-through, load, store with backpressure and its read-back
    run_op(1'b0, 1'b0, 8'h3C, 8'h55, 4'd2, 0, 0);
    run_op(1'b1, 1'b0, 8'h10, 8'h00, 4'd1, 2, 0);
    run_op(1'b0, 1'b1, 8'h20, 8'h7F, 4'd3, 1, 3);
    chk("store_reached_ram", mem[8'h20], 8'h7F);
    run_op(1'b1, 1'b0, 8'h20, 8'h00, 4'd5, 0, 1);

    // timeout and ack on the last allowed cycle
    run_op(1'b1, 1'b0, 8'h30, 8'h00, 4'd4, 100, 0);
    run_op(1'b1, 1'b0, 8'h31, 8'h00, 4'd6, TO - 1, 0);
    run_op(1'b0, 1'b1, 8'h32, 8'h99, 4'd7, 100, 2);

    // illegal read+write
    run_op(1'b1, 1'b1, 8'h40, 8'h11, 4'd8, 0, 1);

    // spurious acks while idle
    for (int i = 0; i < 3; i++) begin
      ram_ack = 1'b1; ram_rdata = $urandom;
      @(negedge clk);
      chk("idle_ack_out_valid", out_valid, 0);
      chk("idle_ack_ram_req", ram_req, 0);
      chk("idle_ack_in_ready", in_ready, 1);
    end
    ram_ack = 1'b0;

    // random traffic
    for (int i = 0; i < 25; i++) begin
      dly = (($urandom % 8) == 0) ? TO + int'($urandom % 4) : int'($urandom % 6);
      if (($urandom % 10) == 0) dly = TO - 1;
      run_op(1'(($urandom % 3) == 0), 1'(($urandom % 3) == 0), 8'($urandom),
             8'($urandom), 4'($urandom), dly, int'($urandom % 4));
    end

    // asynchronous reset in the middle of a read
    @(negedge clk);
    in_valid = 1'b1; in_mem_rd = 1'b1; in_mem_wr = 1'b0;
    in_valE = 8'h55; in_valA = 8'h66; in_dstE = 4'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreq_ram_req", ram_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_ram_req", ram_req, 0);
    chk("post_reset_out_valid", out_valid, 0);
    run_op(1'b0, 1'b0, 8'hE1, 8'h00, 4'd15, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
